sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single-port output-queue SRAM between the packet write path (wr_0, driven by the packet store engine) and the packet read path (rd_0, driven by the output-queue removal engine). It grants one requester at a time with round-robin fairness and a per-grant burst limit, and it inserts a one-cycle bus turnaround on every direct write/read direction switch. It registers all SRAM command signals and returns read data with a fixed latency.

## Interface
- DATA_WIDTH, 64, packet data width
- CTRL_WIDTH, DATA_WIDTH/8, control bits stored with each word
- SRAM_ADDR_WIDTH, 13, SRAM word address width
- SRAM_RD_LATENCY, 2, cycles from SRAM command to sram_rd_data valid (≥1)
- MAX_BURST, 16, maximum accepts per grant while the other side waits (≥1)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- wr_0_req  in  1  write request; addr/data valid while high
- wr_0_addr  in  SRAM_ADDR_WIDTH  write address
- wr_0_data  in  DATA_WIDTH+CTRL_WIDTH  write word {ctrl,data}
- wr_0_ack  out  1  current write accepted this cycle
- rd_0_req  in  1  read request
- rd_0_addr  in  SRAM_ADDR_WIDTH  read address
- rd_0_ack  out  1  current read accepted this cycle
- rd_0_data  out  DATA_WIDTH+CTRL_WIDTH  read word
- rd_0_vld  out  1  rd_0_data valid, one-cycle pulse per accepted read
- sram_addr  out  SRAM_ADDR_WIDTH  registered command address
- sram_we  out  1  registered write enable (1 = write)
- sram_rd_en  out  1  registered read enable
- sram_wr_data  out  DATA_WIDTH+CTRL_WIDTH  registered write data
- sram_rd_data  in  DATA_WIDTH+CTRL_WIDTH  SRAM read return

## Operation
- States: IDLE, GNT_WR, GNT_RD, TURN. A last_gnt flag (WR/RD) and a burst counter (width log2(MAX_BURST)+1, saturating at MAX_BURST) are kept alongside.
- Handshake: wr_0_ack = (state==GNT_WR) & wr_0_req, combinational; rd_0_ack is analogous. A request is consumed on the ack cycle. The requester may present the next address and data in the following cycle with req held high. Dropping req with no ack is legal.
- IDLE: if only one side requests, go to its grant state. If both request, grant the side that is not last_gnt. Stay in IDLE otherwise. The burst counter clears on entry to any grant state.
- GNT_WR: the counter increments on each ack. At the end of the cycle:
  - if !wr_0_req, or (counter after this cycle ≥ MAX_BURST and rd_0_req): go to TURN if rd_0_req, else IDLE;
  - otherwise stay.
  - The ack in the leaving cycle is still honoured.
- GNT_RD: symmetric to GNT_WR.
- TURN: one cycle with no acks, then enter the opposite grant state. A direction switch through IDLE inserts no TURN.
- last_gnt updates on entry to each grant state.
- Command register: on the cycle after an ack, drive sram_addr and sram_we or sram_rd_en, plus sram_wr_data for writes. In all other cycles sram_we and sram_rd_en are 0, and sram_addr and sram_wr_data hold their last values.
- Read return: a valid shift pipeline of depth SRAM_RD_LATENCY+1 runs from sram_rd_en. rd_0_data is registered from sram_rd_data.
- Read data is returned in request order, and no read is ever lost, including across grant switches.

## Timing
- Reset values: state IDLE, last_gnt=RD (write wins the first tie), counter 0, both acks 0, sram_we 0, sram_rd_en 0, sram_addr 0, sram_wr_data 0, rd_0_vld 0, rd_0_data 0. The read valid pipeline clears.
- Reset asserted mid-burst drops every in-flight read: no rd_0_vld is produced for it.
- Request-to-first-ack: one cycle from IDLE, since the state is registered.
- Ack at cycle A gives the SRAM command at A+1. For reads, rd_0_vld and rd_0_data are valid at A+SRAM_RD_LATENCY+2.
- Back-to-back acks sustain one SRAM access per cycle within a grant.
- Direction switch cost:
  - via TURN: 1 dead cycle;
  - via IDLE: 1 IDLE cycle plus the grant-entry cycle.
- Simultaneous requests in IDLE are resolved by last_gnt, never both. The acks are mutually exclusive in every cycle.

## Test plan
- Write burst: wr_0_req rises at cycle 0 with addresses 0x10, 0x11, 0x12, each advanced after its ack. Required: wr_0_ack at cycles 1–3; sram_we=1 at cycles 2–4 with sram_addr 0x10, 0x11, 0x12; req dropped at cycle 4 returns the block to IDLE at cycle 5.
- Single read: rd_0_req at cycle 0 with address 0x20, and the SRAM model returns 0xABCD at cycle 4. Required: rd_0_ack at cycle 1, sram_rd_en at cycle 2, rd_0_vld=1 with rd_0_data=0xABCD at cycle 5 only.
- Contention, MAX_BURST=16, both requests held high from reset release. Required:
  - wr acks at cycles 1–16;
  - TURN at cycle 17;
  - rd acks at cycles 18–33;
  - TURN at cycle 34;
  - wr acks resume at cycle 35.
- Write drop with read waiting: wr_0_req deasserts at cycle 5 of a grant while rd_0_req is high. Required: TURN at the next cycle, then a rd ack; read data order is preserved.
- Tie in IDLE after a read grant: both sides request. Required: write is granted first. Repeating the tie after a write grant: read is granted first.
- Reset mid-read-burst, asserted 1 cycle after rd acks. Required: all outputs reach their reset values the next cycle, and no rd_0_vld pulses follow.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a packet write path and a packet read path.
// Per-grant burst limit, one-cycle turnaround on direct direction switches, registered SRAM commands.
module sram_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int SRAM_ADDR_WIDTH = 13,
   parameter int SRAM_RD_LATENCY = 2,
   parameter int MAX_BURST       = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr_0_req,
   input  logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
   input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
   output logic                             wr_0_ack,
   input  logic                             rd_0_req,
   input  logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
   output logic                             rd_0_ack,
   output logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
   output logic                             rd_0_vld,
   output logic [SRAM_ADDR_WIDTH-1:0]       sram_addr,
   output logic                             sram_we,
   output logic                             sram_rd_en,
   output logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data,
   input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_rd_data
);

   localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
   localparam int CNT_W  = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD, TURN} state_t;
   typedef enum logic {LAST_WR, LAST_RD} side_t;

   state_t                      state_q, state_d;
   side_t                       last_q, last_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CNT_W-1:0]            cntSat;
   logic [CNT_W-1:0]            cntAfter;
   logic                        sram_we_q;
   logic                        sram_rd_en_q;
   logic [SRAM_ADDR_WIDTH-1:0]  sram_addr_q;
   logic [WORD_W-1:0]           sram_wr_data_q;
   logic [SRAM_RD_LATENCY:0]    vld_pipe_q;
   logic [WORD_W-1:0]           rd_data_q;

   assign wr_0_ack = (state_q == GNT_WR) && wr_0_req;
   assign rd_0_ack = (state_q == GNT_RD) && rd_0_req;

   // Burst count as it will stand after this cycle's accept, saturating at the limit.
   assign cntSat   = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
   assign cntAfter = (wr_0_ack || rd_0_ack) ? cntSat : cnt_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (wr_0_req && (!rd_0_req || last_q == LAST_RD)) begin
               state_d = GNT_WR;
               last_d  = LAST_WR;
               cnt_d   = '0;
            end else if (rd_0_req) begin
               state_d = GNT_RD;
               last_d  = LAST_RD;
               cnt_d   = '0;
            end
         end
         GNT_WR: begin
            cnt_d = cntAfter;
            if (!wr_0_req || (cntAfter >= MAX_CNT && rd_0_req)) begin
               state_d = rd_0_req ? TURN : IDLE;
            end
         end
         GNT_RD: begin
            cnt_d = cntAfter;
            if (!rd_0_req || (cntAfter >= MAX_CNT && wr_0_req)) begin
               state_d = wr_0_req ? TURN : IDLE;
            end
         end
         TURN: begin
            cnt_d = '0;
            if (last_q == LAST_WR) begin
               state_d = GNT_RD;
               last_d  = LAST_RD;
            end else begin
               state_d = GNT_WR;
               last_d  = LAST_WR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address and write data hold between accesses; only the enables pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         last_q         <= LAST_RD;
         cnt_q          <= '0;
         sram_we_q      <= 1'b0;
         sram_rd_en_q   <= 1'b0;
         sram_addr_q    <= '0;
         sram_wr_data_q <= '0;
         vld_pipe_q     <= '0;
         rd_data_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         sram_we_q    <= wr_0_ack;
         sram_rd_en_q <= rd_0_ack;
         if (wr_0_ack) begin
            sram_addr_q    <= wr_0_addr;
            sram_wr_data_q <= wr_0_data;
         end else if (rd_0_ack) begin
            sram_addr_q <= rd_0_addr;
         end
         vld_pipe_q <= {vld_pipe_q[SRAM_RD_LATENCY-1:0], sram_rd_en_q};
         if (vld_pipe_q[SRAM_RD_LATENCY-1]) begin
            rd_data_q <= sram_rd_data;
         end
      end
   end

   assign sram_we      = sram_we_q;
   assign sram_rd_en   = sram_rd_en_q;
   assign sram_addr    = sram_addr_q;
   assign sram_wr_data = sram_wr_data_q;
   assign rd_0_vld     = vld_pipe_q[SRAM_RD_LATENCY];
   assign rd_0_data    = rd_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table for single-direction traffic, hand sequences for
// contention, turnaround, tie-breaking and reset, plus an SRAM model and a read-order scoreboard.
module tb_sram_arbiter;

   localparam int AW = 13;
   localparam int WW = 72;

   logic          clk;
   logic          reset;
   logic          wr_0_req;
   logic [AW-1:0] wr_0_addr;
   logic [WW-1:0] wr_0_data;
   logic          wr_0_ack;
   logic          rd_0_req;
   logic [AW-1:0] rd_0_addr;
   logic          rd_0_ack;
   logic [WW-1:0] rd_0_data;
   logic          rd_0_vld;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic          sram_rd_en;
   logic [WW-1:0] sram_wr_data;
   logic [WW-1:0] sram_rd_data;

   int            tests;
   int            fails;
   logic [7:0]    salt;

   sram_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .wr_0_req     (wr_0_req),
      .wr_0_addr    (wr_0_addr),
      .wr_0_data    (wr_0_data),
      .wr_0_ack     (wr_0_ack),
      .rd_0_req     (rd_0_req),
      .rd_0_addr    (rd_0_addr),
      .rd_0_ack     (rd_0_ack),
      .rd_0_data    (rd_0_data),
      .rd_0_vld     (rd_0_vld),
      .sram_addr    (sram_addr),
      .sram_we      (sram_we),
      .sram_rd_en   (sram_rd_en),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WW-1:0] mkData(input logic [AW-1:0] a);
      return {salt, 51'h0, a};
   endfunction

   // SRAM model: a command seen in cycle k returns read data in cycle k+2.
   logic [WW-1:0] sramMem [256];
   logic [WW-1:0] rdStage;
   bit            memInit;
   always @(posedge clk) begin
      if (!memInit) begin
         for (int i = 0; i < 256; i++) sramMem[i] = '0;
         sramMem[8'h20] = 72'hABCD;
         memInit = 1'b1;
      end
      if (sram_we) sramMem[sram_addr[7:0]] = sram_wr_data;
      rdStage      <= sramMem[sram_addr[7:0]];
      sram_rd_data <= rdStage;
   end

   task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference memory updated at accept time; each accepted read queues the word it must return.
   logic [WW-1:0] expMem [256];
   logic [WW-1:0] expQ [$];
   bit            sbInit;
   always @(negedge clk) begin
      if (!sbInit) begin
         for (int i = 0; i < 256; i++) expMem[i] = '0;
         expMem[8'h20] = 72'hABCD;
         sbInit = 1'b1;
      end
      if (reset) begin
         expQ.delete();
      end else begin
         if (rd_0_vld) begin
            if (expQ.size() == 0) checkOutput("rdVldUnexpected", 72'(rd_0_vld), 72'(0));
            else checkOutput("rdOrder", rd_0_data, expQ.pop_front());
         end
         if (wr_0_ack || rd_0_ack) checkOutput("ackExclusive", 72'(wr_0_ack & rd_0_ack), 72'(0));
         if (wr_0_ack) expMem[wr_0_addr[7:0]] = wr_0_data;
         if (rd_0_ack) expQ.push_back(expMem[rd_0_addr[7:0]]);
      end
   end

   task automatic applyStimulus(input logic rst, input logic wr, input logic [AW-1:0] wa,
                                input logic rd, input logic [AW-1:0] ra);
      @(posedge clk);
      #1;
      reset     = rst;
      wr_0_req  = wr;
      wr_0_addr = wa;
      wr_0_data = mkData(wa);
      rd_0_req  = rd;
      rd_0_addr = ra;
   endtask

   task automatic checkAcks(input string tag, input logic eWr, input logic eRd);
      checkOutput({tag, ".wrAck"}, 72'(wr_0_ack), 72'(eWr));
      checkOutput({tag, ".rdAck"}, 72'(rd_0_ack), 72'(eRd));
   endtask

   task automatic checkResetValues(input string tag);
      checkAcks(tag, 1'b0, 1'b0);
      checkOutput({tag, ".we"}, 72'(sram_we), 72'(0));
      checkOutput({tag, ".rdEn"}, 72'(sram_rd_en), 72'(0));
      checkOutput({tag, ".addr"}, 72'(sram_addr), 72'(0));
      checkOutput({tag, ".wrData"}, sram_wr_data, 72'(0));
      checkOutput({tag, ".vld"}, 72'(rd_0_vld), 72'(0));
      checkOutput({tag, ".rdData"}, rd_0_data, 72'(0));
   endtask

   task automatic doReset();
      reset    = 1'b1;
      wr_0_req = 1'b0;
      rd_0_req = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic drain(input string tag);
      repeat (8) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput({tag, ".pendingReads"}, 72'(expQ.size()), 72'(0));
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] wa;
      logic          rd;
      logic [AW-1:0] ra;
      logic          eWrAck;
      logic          eRdAck;
      logic          eWe;
      logic          eRdEn;
      logic [AW-1:0] eAddr;
      logic          eVld;
      logic [WW-1:0] eData;
   } vec_t;

   typedef struct {
      logic wr;
      logic rd;
      logic eWr;
      logic eRd;
   } ackVec_t;

   localparam int NV = 20;
   localparam logic [AW-1:0] Z13 = '0;
   localparam logic [WW-1:0] Z72 = '0;

   vec_t          vecs [NV];
   ackVec_t       tieVecs [9];
   logic [AW-1:0] wa;
   logic [AW-1:0] ra;
   string         tag;
   logic          hold;

   initial begin
      tests    = 0;
      fails    = 0;
      salt     = 8'hA1;
      reset    = 1'b1;
      wr_0_req = 1'b0;
      rd_0_req = 1'b0;
      wr_0_addr = '0;
      wr_0_data = '0;
      rd_0_addr = '0;

      //       wr  wa       rd  ra       wAck rAck we  rdEn addr     vld data
      vecs[0]  = '{'1, 13'h10, '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[1]  = '{'1, 13'h10, '0, Z13,    '1, '0, '0, '0, Z13,    '0, Z72};
      vecs[2]  = '{'1, 13'h11, '0, Z13,    '1, '0, '1, '0, 13'h10, '0, Z72};
      vecs[3]  = '{'1, 13'h12, '0, Z13,    '1, '0, '1, '0, 13'h11, '0, Z72};
      vecs[4]  = '{'0, 13'h12, '0, Z13,    '0, '0, '1, '0, 13'h12, '0, Z72};
      vecs[5]  = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[6]  = '{'0, Z13,    '1, 13'h20, '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[7]  = '{'0, Z13,    '1, 13'h20, '0, '1, '0, '0, Z13,    '0, Z72};
      vecs[8]  = '{'0, Z13,    '0, Z13,    '0, '0, '0, '1, 13'h20, '0, Z72};
      vecs[9]  = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[10] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[11] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '1, 72'hABCD};
      vecs[12] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[13] = '{'0, Z13,    '1, 13'h11, '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[14] = '{'0, Z13,    '1, 13'h11, '0, '1, '0, '0, Z13,    '0, Z72};
      vecs[15] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '1, 13'h11, '0, Z72};
      vecs[16] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[17] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};
      vecs[18] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '1, mkData(13'h11)};
      vecs[19] = '{'0, Z13,    '0, Z13,    '0, '0, '0, '0, Z13,    '0, Z72};

      // Read alone, then two ties: the first after a read grant, the second after a write grant.
      tieVecs[0] = '{'0, '1, '0, '0};
      tieVecs[1] = '{'0, '1, '0, '1};
      tieVecs[2] = '{'0, '0, '0, '0};
      tieVecs[3] = '{'1, '1, '0, '0};
      tieVecs[4] = '{'1, '1, '1, '0};
      tieVecs[5] = '{'0, '0, '0, '0};
      tieVecs[6] = '{'1, '1, '0, '0};
      tieVecs[7] = '{'1, '1, '0, '1};
      tieVecs[8] = '{'0, '0, '0, '0};

      doReset();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkResetValues("reset");

      for (int i = 0; i < NV; i++) begin
         applyStimulus(1'b0, vecs[i].wr, vecs[i].wa, vecs[i].rd, vecs[i].ra);
         @(negedge clk);
         tag = $sformatf("vec%0d", i);
         checkAcks(tag, vecs[i].eWrAck, vecs[i].eRdAck);
         checkOutput({tag, ".we"}, 72'(sram_we), 72'(vecs[i].eWe));
         checkOutput({tag, ".rdEn"}, 72'(sram_rd_en), 72'(vecs[i].eRdEn));
         checkOutput({tag, ".vld"}, 72'(rd_0_vld), 72'(vecs[i].eVld));
         if (vecs[i].eWe || vecs[i].eRdEn) checkOutput({tag, ".addr"}, 72'(sram_addr), 72'(vecs[i].eAddr));
         if (vecs[i].eWe) checkOutput({tag, ".wrData"}, sram_wr_data, mkData(vecs[i].eAddr));
         if (vecs[i].eVld) checkOutput({tag, ".rdData"}, rd_0_data, vecs[i].eData);
      end
      drain("vec");

      // Contention with both sides saturating their bursts.
      salt = 8'hB2;
      doReset();
      wa = 13'h40;
      ra = 13'h40;
      for (int c = 0; c <= 37; c++) begin
         hold = (c <= 36);
         applyStimulus(1'b0, hold, wa, hold, ra);
         @(negedge clk);
         checkAcks($sformatf("cont%0d", c),
                   (c >= 1 && c <= 16) || (c >= 35 && c <= 36),
                   (c >= 18 && c <= 33));
         if (wr_0_ack) wa = wa + 1'b1;
         if (rd_0_ack) ra = ra + 1'b1;
      end
      drain("cont");

      // Write side drops while a read waits: turnaround, then reads of the fresh data.
      salt = 8'hC3;
      doReset();
      wa = 13'h40;
      ra = 13'h40;
      for (int c = 0; c <= 11; c++) begin
         applyStimulus(1'b0, c <= 4, wa, c <= 10, ra);
         @(negedge clk);
         checkAcks($sformatf("wdrop%0d", c), (c >= 1 && c <= 4), (c >= 7 && c <= 10));
         if (wr_0_ack) wa = wa + 1'b1;
         if (rd_0_ack) ra = ra + 1'b1;
      end
      drain("wdrop");

      salt = 8'hD4;
      doReset();
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1'b0, tieVecs[c].wr, 13'h60, tieVecs[c].rd, 13'h20);
         @(negedge clk);
         checkAcks($sformatf("tie%0d", c), tieVecs[c].eWr, tieVecs[c].eRd);
      end

      // Reset lands in the middle of a read burst; no accepted read may return afterwards.
      for (int c = 0; c <= 3; c++) begin
         applyStimulus(c == 3, 1'b0, '0, 1'b1, 13'h20);
         @(negedge clk);
         checkAcks($sformatf("rstBurst%0d", c), 1'b0, c >= 1);
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checkResetValues("rstBurst4");
      for (int c = 5; c <= 12; c++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
         @(negedge clk);
         checkOutput($sformatf("rstBurst%0d.vld", c), 72'(rd_0_vld), 72'(0));
      end
      checkOutput("rstBurst.pendingReads", 72'(expQ.size()), 72'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
